// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demultiplexing router.
//   N_CH          number of output channels
//   CH_W          width of the channel select field
//   DEF_DATA_W    default word width
//   DEF_DEPTH     default per-channel FIFO depth (power of two, >= 2)
package demux_pkg;
    localparam int N_CH       = 4;
    localparam int CH_W       = 2;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 2;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// The head word is presented on dout whenever empty is low.
// Ports:
//   clk    clock, all state on rising edge
//   rst    synchronous active-high reset; empties the FIFO
//   push   write din this cycle (ignored while full)
//   din    write data
//   pop    remove head word this cycle (ignored while empty)
//   dout   head word (undefined content while empty)
//   full   no free entry
//   empty  no stored entry
module sync_fifo_fwft #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells a full FIFO from an empty one.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are only meaningful while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
endmodule

// File: rtl/demux4_router.sv
// 1-to-4 registered demultiplexer. Each accepted input word is steered by
// i_ctrl into one of four FWFT FIFOs; each FIFO drains through its own
// valid/ready port. Order is kept per channel only.
// Ports:
//   i_clk, i_rst           clock / synchronous active-high reset
//   i_valid, o_ready       input handshake; o_ready = channel i_ctrl not full
//   i_ctrl, i_data         destination channel and word, sampled on handshake
//   o_data_n, o_valid_n    head word / non-empty flag of channel n (0..3)
//   i_ready_n              downstream n takes the head word
module demux4_router
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CH_W-1:0]   i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data_0,
    output logic [DATA_W-1:0] o_data_1,
    output logic [DATA_W-1:0] o_data_2,
    output logic [DATA_W-1:0] o_data_3,
    output logic              o_valid_0,
    output logic              o_valid_1,
    output logic              o_valid_2,
    output logic              o_valid_3,
    input  logic              i_ready_0,
    input  logic              i_ready_1,
    input  logic              i_ready_2,
    input  logic              i_ready_3
);
    logic [N_CH-1:0]   ch_push;
    logic [N_CH-1:0]   ch_pop;
    logic [N_CH-1:0]   ch_full;
    logic [N_CH-1:0]   ch_empty;
    logic [N_CH-1:0]   ch_ready;
    logic [DATA_W-1:0] ch_head [N_CH];
    logic [DATA_W-1:0] ch_data [N_CH];
    logic              accept;

    assign ch_ready = {i_ready_3, i_ready_2, i_ready_1, i_ready_0};

    // Depends only on FIFO state and i_ctrl, never on any downstream ready.
    assign o_ready = !ch_full[i_ctrl];
    assign accept  = i_valid && o_ready;

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        assign ch_push[n] = accept && (i_ctrl == CH_W'(n));
        assign ch_pop[n]  = ch_ready[n] && !ch_empty[n];

        sync_fifo_fwft #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (i_clk),
            .rst   (i_rst),
            .push  (ch_push[n]),
            .din   (i_data),
            .pop   (ch_pop[n]),
            .dout  (ch_head[n]),
            .full  (ch_full[n]),
            .empty (ch_empty[n])
        );

        // Stale storage must never be visible on an empty channel.
        assign ch_data[n] = ch_empty[n] ? '0 : ch_head[n];
    end

    assign o_data_0  = ch_data[0];
    assign o_data_1  = ch_data[1];
    assign o_data_2  = ch_data[2];
    assign o_data_3  = ch_data[3];
    assign o_valid_0 = !ch_empty[0];
    assign o_valid_1 = !ch_empty[1];
    assign o_valid_2 = !ch_empty[2];
    assign o_valid_3 = !ch_empty[3];
endmodule

// File: tb/tb_demux4_router.sv
module tb_demux4_router;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic [15:0] od0, od1, od2, od3;
    logic        ov0, ov1, ov2, ov3;
    logic [3:0]  rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux4_router #(.DATA_W(16), .DEPTH(2)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .o_ready   (ready),
        .i_ctrl    (ctrl),
        .i_data    (data),
        .o_data_0  (od0),
        .o_data_1  (od1),
        .o_data_2  (od2),
        .o_data_3  (od3),
        .o_valid_0 (ov0),
        .o_valid_1 (ov1),
        .o_valid_2 (ov2),
        .o_valid_3 (ov3),
        .i_ready_0 (rdy[0]),
        .i_ready_1 (rdy[1]),
        .i_ready_2 (rdy[2]),
        .i_ready_3 (rdy[3])
    );

    // Inputs applied for one cycle; expected outputs are those seen during
    // that cycle, i.e. before the rising edge that samples the inputs.
    typedef struct {
        logic             rst;
        logic             valid;
        logic [1:0]       ctrl;
        logic [15:0]      data;
        logic [3:0]       rdy;
        logic             exp_ready;
        logic [3:0]       exp_valid;
        logic [3:0][15:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [1:0] c,
                       input logic [15:0] d, input logic [3:0] rd,
                       input logic er, input logic [3:0] ev,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3);
        vec_t t;
        t.rst = r; t.valid = v; t.ctrl = c; t.data = d; t.rdy = rd;
        t.exp_ready = er; t.exp_valid = ev;
        t.exp_data = {e3, e2, e1, e0};
        vecs.push_back(t);
    endtask

    task automatic check_outputs(input string name, input logic er,
                                 input logic [3:0] ev, input logic [63:0] ed);
        logic [3:0]  av;
        logic [63:0] ad;
        av = {ov3, ov2, ov1, ov0};
        ad = {od3, od2, od1, od0};
        checks++;
        if (ready !== er) begin
            failures++;
            $display("FAIL %s o_ready: got %b want %b", name, ready, er);
        end
        checks++;
        if (av !== ev) begin
            failures++;
            $display("FAIL %s o_valid[3:0]: got %b want %b", name, av, ev);
        end
        checks++;
        if (ad !== ed) begin
            failures++;
            $display("FAIL %s o_data{3,2,1,0}: got %h want %h", name, ad, ed);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] c,
                         input logic [15:0] d, input logic [3:0] rd);
        @(negedge clk);
        rst = r; valid = v; ctrl = c; data = d; rdy = rd;
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; ctrl = 2'd0; data = 16'd0; rdy = 4'b0000;

        // reset state
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // reset held 2 cycles mid-traffic
        add(0,1,1,16'h31,4'b0000, 1,4'b0000, 0,0,0,0);
        add(0,1,3,16'h33,4'b0000, 1,4'b0010, 0,16'h31,0,0);
        add(1,1,2,16'h32,4'b0000, 1,4'b1010, 0,16'h31,0,16'h33);
        add(1,1,2,16'h32,4'b0000, 1,4'b0000, 0,0,0,0);
        add(0,0,2,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // route to each channel
        add(0,1,0,16'd5,4'b1111, 1,4'b0000, 0,0,0,0);
        add(0,1,1,16'd4,4'b1111, 1,4'b0001, 16'd5,0,0,0);
        add(0,1,2,16'd3,4'b1111, 1,4'b0010, 0,16'd4,0,0);
        add(0,1,3,16'd2,4'b1111, 1,4'b0100, 0,0,16'd3,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b1000, 0,0,0,16'd2);
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // backpressure on ch2
        add(0,1,2,16'hA1,4'b1011, 1,4'b0000, 0,0,0,0);
        add(0,1,2,16'hA2,4'b1011, 1,4'b0100, 0,0,16'hA1,0);
        add(0,1,2,16'hA3,4'b1011, 0,4'b0100, 0,0,16'hA1,0);
        add(0,1,2,16'hA3,4'b1111, 0,4'b0100, 0,0,16'hA1,0);
        add(0,1,2,16'hA3,4'b1111, 1,4'b0100, 0,0,16'hA2,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0100, 0,0,16'hA3,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // steady stream on ch1 (also wraps the pointers several times)
        for (int i = 0; i < 8; i++)
            add(0,1,1,16'(10+i),4'b1111, 1,{2'b00,(i>0),1'b0},
                0,(i>0) ? 16'(9+i) : 16'd0,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0010, 0,16'd17,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // select change while stalled on full ch1
        add(0,1,1,16'h11,4'b1101, 1,4'b0000, 0,0,0,0);
        add(0,1,1,16'h12,4'b1101, 1,4'b0010, 0,16'h11,0,0);
        add(0,1,1,16'h13,4'b1101, 0,4'b0010, 0,16'h11,0,0);
        add(0,1,3,16'd55,4'b1101, 1,4'b0010, 0,16'h11,0,0);
        add(0,0,0,16'h0,4'b1101, 1,4'b1010, 0,16'h11,0,16'd55);
        add(0,0,0,16'h0,4'b1111, 1,4'b0010, 0,16'h11,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0010, 0,16'h12,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // reset mid-op with ch0 full
        add(0,1,0,16'h21,4'b1110, 1,4'b0000, 0,0,0,0);
        add(0,1,0,16'h22,4'b1110, 1,4'b0001, 16'h21,0,0,0);
        add(1,0,0,16'h0,4'b1110, 0,4'b0001, 16'h21,0,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);
        add(0,1,0,16'd7,4'b1111, 1,4'b0000, 0,0,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0001, 16'd7,0,0,0);
        add(0,0,0,16'h0,4'b1111, 1,4'b0000, 0,0,0,0);

        // initial reset: two edges
        @(negedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].ctrl, vecs[i].data, vecs[i].rdy);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_ready,
                          vecs[i].exp_valid, vecs[i].exp_data);
        end

        // Hand-written: fill every channel, then pop all four at once while
        // pushing a new word to ch0 in the same cycle.
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, 2'(n), 16'(16'h40 + n), 4'b0000);
        end
        drive(0, 1, 2'd0, 16'h44, 4'b1111);
        check_outputs("all_heads", 1'b1, 4'b1111, {16'h43, 16'h42, 16'h41, 16'h40});
        drive(0, 0, 2'd0, 16'h0, 4'b0000);
        check_outputs("push_with_pops", 1'b1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h44});
        drive(0, 0, 2'd0, 16'h0, 4'b0001);
        check_outputs("hold_ch0", 1'b1, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h44});
        drive(0, 0, 2'd0, 16'h0, 4'b0000);
        check_outputs("drained", 1'b1, 4'b0000, 64'h0);

        // Hand-written: ch3 full, stall on it, ready_3 ignored while empty elsewhere.
        drive(0, 1, 2'd3, 16'h51, 4'b0000);
        drive(0, 1, 2'd3, 16'h52, 4'b0000);
        drive(0, 1, 2'd3, 16'h53, 4'b0000);
        check_outputs("ch3_full_stall", 1'b0, 4'b1000, {16'h51, 16'h0, 16'h0, 16'h0});
        drive(0, 1, 2'd3, 16'h53, 4'b1000);
        check_outputs("ch3_pop_full", 1'b0, 4'b1000, {16'h51, 16'h0, 16'h0, 16'h0});
        drive(0, 0, 2'd3, 16'h0, 4'b1000);
        check_outputs("ch3_second", 1'b1, 4'b1000, {16'h52, 16'h0, 16'h0, 16'h0});
        drive(0, 0, 2'd3, 16'h0, 4'b0000);
        check_outputs("ch3_empty", 1'b1, 4'b0000, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
